// File: rtl/instruction_fetch_responder.sv
// Fetch responder: accepts PC fetch addresses, performs one outstanding memory read at a time and
// returns {addr, instr, fault} through a show-ahead FIFO. Optional macro: IFETCH_ALIGN_CHECK_EN.
module instruction_fetch_responder #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        flush,
  output logic        mem_read,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_addr,
  output logic [31:0] rsp_instr,
  output logic        rsp_fault
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_MEM,
    DRAIN
  } state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] instr;
    logic        fault;
  } entry_t;

  state_e             state_q, state_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic [31:0]        req_addr_q, req_addr_d;
  entry_t             fifo_q [DEPTH];
  entry_t             fifo_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic   accept;
  logic   misaligned;
  logic   push;
  logic   pop;
  entry_t push_entry;
  entry_t head;

`ifdef IFETCH_ALIGN_CHECK_EN
  assign misaligned = (req_addr[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign req_ready = !reset && (state_q == IDLE) && (count_q < DEPTH_C) && !flush;
  assign accept    = req_valid && req_ready;
  assign mem_read  = (state_q != IDLE);
  assign mem_addr  = mem_addr_q;

  // Request/memory FSM; it is also the only source of FIFO pushes.
  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    req_addr_d = req_addr_q;
    push       = 1'b0;
    push_entry = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (misaligned) begin
            push       = 1'b1;
            push_entry = '{addr: req_addr, instr: '0, fault: 1'b1};
          end else begin
            state_d    = WAIT_MEM;
            mem_addr_d = {req_addr[31:2], 2'b00};
            req_addr_d = req_addr;
          end
        end
      end
      WAIT_MEM: begin
        if (mem_ready) begin
          state_d = IDLE;
          if (!flush) begin
            push       = 1'b1;
            push_entry = '{addr: req_addr_q, instr: mem_rdata, fault: 1'b0};
          end
        end else if (flush) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (mem_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A free slot is reserved at accept time, so push never meets a full FIFO.
  always_comb begin
    pop      = (count_q != '0) && rsp_ready && !flush;
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        fifo_d[wr_ptr_q] = push_entry;
        wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  assign head      = fifo_q[rd_ptr_q];
  assign rsp_valid = (count_q != '0);
  assign rsp_addr  = rsp_valid ? head.addr  : '0;
  assign rsp_instr = rsp_valid ? head.instr : '0;
  assign rsp_fault = rsp_valid ? head.fault : 1'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      mem_addr_q <= '0;
      req_addr_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      mem_addr_q <= mem_addr_d;
      req_addr_q <= req_addr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      fifo_q     <= fifo_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_responder.sv
// Scoreboard bench for instruction_fetch_responder: directed fetches, back-pressure, flush and async reset.
module tb_instruction_fetch_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        flush;
  logic        mem_read;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_addr;
  logic [31:0] rsp_instr;
  logic        rsp_fault;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  logic [64:0] sb [$];

  int unsigned mem_lat    = 1;
  logic        use_ovr    = 1'b0;
  logic [31:0] ovr_data   = '0;
  int unsigned burst      = 0;
  int unsigned last_burst = 0;
  int unsigned wait_cnt   = 0;

  instruction_fetch_responder #(.DEPTH(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .flush     (flush),
    .mem_read  (mem_read),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_addr  (rsp_addr),
    .rsp_instr (rsp_instr),
    .rsp_fault (rsp_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input bit expect_rsp, input logic [31:0] instr,
                      input logic fault);
    int unsigned n = 0;
    req_valid = 1'b1;
    req_addr  = a;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    check("req_ready_wait", {31'b0, req_ready}, 32'd1);
    if (expect_rsp) sb.push_back({a, instr, fault});
    tick();
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned n = 0;
    rsp_ready = 1'b1;
    while ((sb.size() != 0 || rsp_valid) && n < 50) begin
      tick();
      n++;
    end
    check("drain_sb_empty", 32'(sb.size()), 32'd0);
    check("drain_rsp_valid", {31'b0, rsp_valid}, 32'd0);
  endtask

  // Memory model: mem_ready after mem_lat sampled cycles of mem_read; data derived from address.
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_ready = 1'b0;
      if (mem_read && !reset) begin
        burst++;
        wait_cnt++;
        if (wait_cnt >= mem_lat) begin
          mem_ready = 1'b1;
          mem_rdata = use_ovr ? ovr_data : (32'hC0DE_0000 | {16'h0, mem_addr[15:0]});
          wait_cnt  = 0;
        end
      end else begin
        if (burst != 0) last_burst = burst;
        burst    = 0;
        wait_cnt = 0;
      end
    end
  end

  initial begin : monitor
    logic [64:0] e;
    forever begin
      @(negedge clk);
      if (!reset && rsp_valid && rsp_ready && !flush) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_rsp: got addr %h instr %h fault %b, expected none",
                   rsp_addr, rsp_instr, rsp_fault);
        end else begin
          e = sb.pop_front();
          check("rsp_addr", rsp_addr, e[64:33]);
          check("rsp_instr", rsp_instr, e[32:1]);
          check("rsp_fault", {31'b0, rsp_fault}, {31'b0, e[0]});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    flush     = 1'b0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", {31'b0, req_ready}, 32'd0);
    check("rst_mem_read", {31'b0, mem_read}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_addr", rsp_addr, 32'h0);
    check("rst_rsp_instr", rsp_instr, 32'h0);
    check("rst_rsp_fault", {31'b0, rsp_fault}, 32'd0);
    reset = 1'b0;
    tick();

    // 1: single fetch, 3-cycle memory
    mem_lat   = 3;
    use_ovr   = 1'b1;
    ovr_data  = 32'hDEAD_BEEF;
    rsp_ready = 1'b1;
    send(32'h0000_0100, 1'b1, 32'hDEAD_BEEF, 1'b0);
    drain();
    check("t1_mem_read_cycles", last_burst, 32'd3);
    use_ovr = 1'b0;

    // 2: back-pressure with DEPTH=2
    mem_lat   = 1;
    rsp_ready = 1'b0;
    send(32'h0, 1'b1, 32'hC0DE_0000, 1'b0);
    send(32'h4, 1'b1, 32'hC0DE_0004, 1'b0);
    tick();
    req_valid = 1'b1;
    req_addr  = 32'h8;
    check("t2_full_req_ready", {31'b0, req_ready}, 32'd0);
    check("t2_head_addr", rsp_addr, 32'h0);
    tick();
    check("t2_still_blocked", {31'b0, req_ready}, 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("t2_ready_after_pop", {31'b0, req_ready}, 32'd1);
    send(32'h8, 1'b1, 32'hC0DE_0008, 1'b0);
    drain();

    // 3: flush during WAIT_MEM, memory completes later
    mem_lat   = 3;
    use_ovr   = 1'b1;
    ovr_data  = 32'h1111_1111;
    rsp_ready = 1'b1;
    send(32'h180, 1'b0, 32'h0, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t3_drain_mem_read", {31'b0, mem_read}, 32'd1);
    check("t3_drain_mem_addr", mem_addr, 32'h180);
    check("t3_drain_req_ready", {31'b0, req_ready}, 32'd0);
    tick();
    check("t3_drain_req_ready2", {31'b0, req_ready}, 32'd0);
    tick();
    check("t3_after_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("t3_after_req_ready", {31'b0, req_ready}, 32'd1);
    check("t3_after_mem_read", {31'b0, mem_read}, 32'd0);
    use_ovr = 1'b0;
    send(32'h200, 1'b1, 32'hC0DE_0200, 1'b0);
    drain();

    // 4: flush coincident with pop
    mem_lat   = 1;
    rsp_ready = 1'b0;
    send(32'h10, 1'b1, 32'hC0DE_0010, 1'b0);
    send(32'h14, 1'b1, 32'hC0DE_0014, 1'b0);
    tick();
    check("t4_full_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    flush     = 1'b1;
    rsp_ready = 1'b1;
    tick();
    flush     = 1'b0;
    rsp_ready = 1'b0;
    sb.delete();
    check("t4_flushed_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("t4_flushed_rsp_addr", rsp_addr, 32'h0);
    rsp_ready = 1'b1;
    repeat (3) tick();
    check("t4_still_empty", {31'b0, rsp_valid}, 32'd0);
    rsp_ready = 1'b0;

    // 5: misaligned request
    rsp_ready = 1'b1;
`ifdef IFETCH_ALIGN_CHECK_EN
    send(32'h0000_0102, 1'b1, 32'h0, 1'b1);
    check("t5_no_mem_read", {31'b0, mem_read}, 32'd0);
    check("t5_rsp_valid_1edge", {31'b0, rsp_valid}, 32'd1);
`else
    send(32'h0000_0102, 1'b1, 32'hC0DE_0100, 1'b0);
    check("t5_mem_addr", mem_addr, 32'h100);
    check("t5_mem_read", {31'b0, mem_read}, 32'd1);
`endif
    drain();

    // 6: async reset mid-WAIT_MEM with one queued entry
    rsp_ready = 1'b0;
    mem_lat   = 1;
    send(32'h0, 1'b1, 32'hC0DE_0000, 1'b0);
    tick();
    mem_lat = 5;
    send(32'h20, 1'b0, 32'h0, 1'b0);
    check("t6_pre_mem_read", {31'b0, mem_read}, 32'd1);
    check("t6_pre_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    #3;
    reset = 1'b1;
    #1;
    check("t6_rst_mem_read", {31'b0, mem_read}, 32'd0);
    check("t6_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("t6_rst_rsp_addr", rsp_addr, 32'h0);
    check("t6_rst_req_ready", {31'b0, req_ready}, 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
    mem_lat   = 2;
    rsp_ready = 1'b1;
    send(32'h40, 1'b1, 32'hC0DE_0040, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
